// File: rtl/spi_sclk_gen_if.sv
// Control/status bundle between the SPI control FSM and the SCLK generator.
// The master side issues transactions; the slave side is the generator.
interface spi_sclk_gen_if #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 6
);
   logic             start;
   logic [DIV_W-1:0] div;
   logic             cpol;
   logic             cpha;
   logic [CNT_W-1:0] num_bits;
   logic             busy;
   logic             done;
   logic             sclk;
   logic             launch_stb;
   logic             sample_stb;
   logic [CNT_W-1:0] bit_idx;

   modport master (
      output start, div, cpol, cpha, num_bits,
      input  busy, done, sclk, launch_stb, sample_stb, bit_idx
   );

   modport slave (
      input  start, div, cpol, cpha, num_bits,
      output busy, done, sclk, launch_stb, sample_stb, bit_idx
   );
endinterface

// File: rtl/spi_sclk_gen.sv
// Programmable SPI serial-clock generator with runtime divisor, CPOL/CPHA
// and a bounded burst of SCLK edges; all outputs registered.
module spi_sclk_gen #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 6
) (
   input  logic         clk_in,
   input  logic         sync_rst,
   spi_sclk_gen_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACTIVE,
      S_HOLD
   } state_e;

   localparam logic [DIV_W-1:0] HP_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] BI_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W:0]   EC_ONE = {{CNT_W{1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q;
   logic             cpol_q;
   logic             cpha_q;
   logic [CNT_W-1:0] nb_q;
   logic [DIV_W-1:0] hp_q, hp_d;
   logic [CNT_W:0]   ec_q, ec_d;
   logic [CNT_W:0]   ec_nxt;
   logic [CNT_W:0]   ec_end;
   logic [CNT_W-1:0] bidx_q, bidx_d;
   logic             sclk_q, sclk_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             lstb_q, lstb_d;
   logic             sstb_q, sstb_d;
   logic             tick;
   logic             last;
   logic             zero;
   logic             acc;

   assign tick   = (hp_q == div_q);
   assign ec_nxt = ec_q + EC_ONE;
   assign ec_end = {nb_q, 1'b0};
   assign last   = (ec_nxt == ec_end);
   assign zero   = (bus.num_bits == '0);
   assign acc    = (state_q == S_IDLE) && bus.start && !zero;

   always_ff @(posedge clk_in) begin
      if (sync_rst) begin
         state_q <= S_IDLE;
         hp_q    <= '0;
         ec_q    <= '0;
         bidx_q  <= '0;
         sclk_q  <= bus.cpol;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lstb_q  <= 1'b0;
         sstb_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hp_q    <= hp_d;
         ec_q    <= ec_d;
         bidx_q  <= bidx_d;
         sclk_q  <= sclk_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         lstb_q  <= lstb_d;
         sstb_q  <= sstb_d;
      end
   end

   // Transaction configuration is frozen for the whole burst.
   always_ff @(posedge clk_in) begin
      if (sync_rst) begin
         div_q  <= '0;
         cpol_q <= 1'b0;
         cpha_q <= 1'b0;
         nb_q   <= '0;
      end else if (acc) begin
         div_q  <= bus.div;
         cpol_q <= bus.cpol;
         cpha_q <= bus.cpha;
         nb_q   <= bus.num_bits;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (acc)          state_d = S_SETUP;
         S_SETUP:  if (tick)         state_d = S_ACTIVE;
         S_ACTIVE: if (tick && last) state_d = S_HOLD;
         S_HOLD:   if (tick)         state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hp_d   = tick ? '0 : hp_q + HP_ONE;
      ec_d   = ec_q;
      sclk_d = sclk_q;
      busy_d = busy_q;
      lstb_d = 1'b0;
      sstb_d = 1'b0;
      bidx_d = bidx_q;
      if (sstb_q && (bidx_q != nb_q))
         bidx_d = bidx_q + BI_ONE;
      unique case (state_q)
         S_IDLE: begin
            hp_d   = '0;
            ec_d   = '0;
            sclk_d = bus.cpol;
            bidx_d = '0;
            busy_d = acc;
            lstb_d = acc && !bus.cpha;
         end
         S_SETUP: begin
            sclk_d = cpol_q;
         end
         S_ACTIVE: begin
            if (tick) begin
               ec_d   = ec_nxt;
               sclk_d = ~sclk_q;
               // Odd edges are leading, even edges trailing.
               if (ec_nxt[0]) begin
                  lstb_d = cpha_q;
                  sstb_d = !cpha_q;
               end else begin
                  lstb_d = !cpha_q && !last;
                  sstb_d = cpha_q;
               end
            end
         end
         S_HOLD: begin
            if (tick) begin
               busy_d = 1'b0;
               bidx_d = '0;
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
      // done marks the last busy cycle, or the cycle after a zero-bit start.
      done_d = ((state_q == S_IDLE) && bus.start && zero) ||
               ((state_d == S_HOLD) && (hp_d == div_q));
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.sclk       = sclk_q;
   assign bus.launch_stb = lstb_q;
   assign bus.sample_stb = sstb_q;
   assign bus.bit_idx    = bidx_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Randomized and directed bench for spi_sclk_gen against a phase-arithmetic
// reference model of the SCLK burst.
module tb_spi_sclk_gen;

   localparam int DIV_W = 16;
   localparam int CNT_W = 6;

   logic clk_in = 1'b0;
   logic sync_rst;

   always #5 clk_in = ~clk_in;

   spi_sclk_gen_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

   spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .clk_in  (clk_in),
      .sync_rst(sync_rst),
      .bus     (bus.slave)
   );

   int n_chk = 0;
   int n_err = 0;

   // model: off = cycle offset inside the busy window (0 when idle)
   int off = 0;
   int m_L, m_d, m_n, samples;
   bit m_pha, m_pol, idle_pol, zdone;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // phase j: 0 setup, 1 first active, j>=2 follows edge k=j-1
   function automatic int m_edge(input int o);
      int j;
      if ((o - 1) % (m_d + 1) != 0) return 0;
      j = (o - 1) / (m_d + 1);
      return (j >= 2) ? j - 1 : 0;
   endfunction

   function automatic bit m_samp(input int o);
      int k;
      k = m_edge(o);
      if (k == 0) return 1'b0;
      return m_pha ? (k % 2 == 0) : (k % 2 == 1);
   endfunction

   function automatic bit m_launch(input int o);
      int k;
      if (o == 1) return !m_pha;
      k = m_edge(o);
      if (k == 0) return 1'b0;
      return m_pha ? (k % 2 == 1) : (k % 2 == 0 && k != 2 * m_n);
   endfunction

   function automatic bit m_sclk(input int o);
      int j, k;
      j = (o - 1) / (m_d + 1);
      k = (j < 1) ? 0 : j - 1;
      return m_pol ^ (k % 2 == 1);
   endfunction

   task automatic step();
      bit st, pl, ph, r;
      int dv, nb;
      st = bus.start;
      pl = bus.cpol;
      ph = bus.cpha;
      dv = int'(bus.div);
      nb = int'(bus.num_bits);
      r  = sync_rst;
      @(posedge clk_in);
      zdone = 1'b0;
      if (r) begin
         off = 0;
         idle_pol = pl;
      end else if (off == 0) begin
         idle_pol = pl;
         if (st) begin
            if (nb == 0) zdone = 1'b1;
            else begin
               off = 1;
               m_d = dv; m_n = nb; m_pha = ph; m_pol = pl;
               m_L = (2 * m_n + 2) * (m_d + 1);
               samples = 0;
            end
         end
      end else begin
         samples += int'(m_samp(off));
         off++;
         if (off > m_L) begin
            off = 0;
            idle_pol = m_pol;
         end
      end
      #1;
      if (off == 0) begin
         chk("busy", int'(bus.busy), 0);
         chk("done", int'(bus.done), int'(zdone));
         chk("sclk", int'(bus.sclk), int'(idle_pol));
         chk("launch", int'(bus.launch_stb), 0);
         chk("sample", int'(bus.sample_stb), 0);
         chk("bit_idx", int'(bus.bit_idx), 0);
      end else begin
         chk("busy", int'(bus.busy), 1);
         chk("done", int'(bus.done), int'(off == m_L));
         chk("sclk", int'(bus.sclk), int'(m_sclk(off)));
         chk("launch", int'(bus.launch_stb), int'(m_launch(off)));
         chk("sample", int'(bus.sample_stb), int'(m_samp(off)));
         chk("bit_idx", int'(bus.bit_idx), samples);
      end
   endtask

   task automatic run_txn(input int d, input int n, input bit pl,
                          input bit ph, input int hold, input int lim,
                          input bit rnd);
      int nbusy, nl, ns, nd, ne;
      bit seen, fin, prev;
      nbusy = 0; nl = 0; ns = 0; nd = 0; ne = 0;
      seen = 1'b0; fin = 1'b0;
      bus.div      = DIV_W'(d);
      bus.num_bits = CNT_W'(n);
      bus.cpol     = pl;
      bus.cpha     = ph;
      bus.start    = 1'b0;
      step();
      prev = bus.sclk;
      for (int i = 0; i < lim && !fin; i++) begin
         bus.start = (i < hold);
         if (rnd && i > 0) begin
            bus.div      = DIV_W'($urandom_range(0, 7));
            bus.cpol     = 1'($urandom);
            bus.cpha     = 1'($urandom);
            bus.num_bits = CNT_W'($urandom_range(0, 9));
         end
         step();
         if (bus.busy) begin
            nbusy++;
            seen = 1'b1;
            if (bus.sclk != prev) ne++;
         end
         nl += int'(bus.launch_stb);
         ns += int'(bus.sample_stb);
         nd += int'(bus.done);
         prev = bus.sclk;
         if (seen && !bus.busy) fin = 1'b1;
      end
      bus.start = 1'b0;
      if (n != 0) chk("finished", int'(fin), 1);
      chk("busy_len", nbusy, (n == 0) ? 0 : (2 * n + 2) * (d + 1));
      chk("edges", ne, 2 * n);
      chk("launches", nl, n);
      chk("samples", ns, n);
      chk("dones", nd, 1);
   endtask

   initial begin
      int ne;
      bit prev;
      sync_rst     = 1'b1;
      bus.start    = 1'b0;
      bus.div      = '0;
      bus.cpol     = 1'b0;
      bus.cpha     = 1'b0;
      bus.num_bits = '0;
      step();
      step();
      sync_rst = 1'b0;
      step();

      run_txn(1, 8, 1'b0, 1'b0, 1, 200, 1'b0);
      run_txn(0, 1, 1'b1, 1'b1, 1, 50, 1'b0);
      run_txn(3, 4, 1'b0, 1'b1, 40, 200, 1'b0);
      run_txn(3, 4, 1'b1, 1'b1, 1, 200, 1'b0);
      run_txn(2, 0, 1'b1, 1'b0, 1, 4, 1'b0);
      run_txn(2, 5, 1'b0, 1'b0, 1, 200, 1'b1);
      run_txn(1, 63, 1'b1, 1'b0, 1, 600, 1'b0);

      // reset in the middle of an 8-bit burst
      bus.div = DIV_W'(1); bus.num_bits = CNT_W'(8);
      bus.cpol = 1'b1; bus.cpha = 1'b0;
      step();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      prev = bus.sclk;
      ne = 0;
      for (int i = 0; i < 100 && ne < 5; i++) begin
         step();
         if (bus.sclk != prev) ne++;
         prev = bus.sclk;
      end
      chk("rst_edge5", ne, 5);
      sync_rst = 1'b1;
      step();
      sync_rst = 1'b0;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_sclk", int'(bus.sclk), 1);
      chk("rst_bidx", int'(bus.bit_idx), 0);
      run_txn(1, 3, 1'b0, 1'b1, 1, 100, 1'b0);

      for (int c = 0; c < 3000; c++) begin
         sync_rst     = ($urandom_range(0, 299) == 0);
         bus.start    = ($urandom_range(0, 3) == 0);
         bus.div      = DIV_W'($urandom_range(0, 3));
         bus.cpol     = 1'($urandom);
         bus.cpha     = 1'($urandom);
         bus.num_bits = ($urandom_range(0, 19) == 0) ?
                        CNT_W'($urandom_range(0, 63)) :
                        CNT_W'($urandom_range(0, 5));
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
